// File: rtl/rv_iopmp_pkg.sv
// Shared types and constants for the IOPMP entry SRAM arbiter.
package rv_iopmp_pkg;

  localparam int ENTRY_WIDTH    = 128;
  localparam int ENTRY_BE_WIDTH = ENTRY_WIDTH / 8;
  localparam int IDX_W          = 8;

  typedef logic [ENTRY_WIDTH-1:0] entry_t;

  // Read-return tag: which requester owns the data coming back next cycle.
  typedef struct packed {
    logic             valid;
    logic             is_cfg;
    logic [IDX_W-1:0] idx;
  } arb_tag_t;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_iopmp_entry_arbiter_if.sv
// Request/grant and SRAM signals of the IOPMP entry arbiter.
interface rv_iopmp_entry_arbiter_if
  import rv_iopmp_pkg::*;
#(
  parameter int NUM_READERS    = 2,
  parameter int NUMBER_ENTRIES = 8,
  parameter int ENTRY_WIDTH    = rv_iopmp_pkg::ENTRY_WIDTH
);
  localparam int AW  = addr_width(NUMBER_ENTRIES);
  localparam int BEW = ENTRY_WIDTH / 8;

  // Handshake: a requester raises req and holds req plus address/data stable
  // until it sees gnt in the same cycle; gnt is combinational and at most one
  // requester is granted per cycle; a read grant is answered by exactly one
  // rvalid pulse (with rdata) in the following cycle, writes get no rvalid.
  logic                      cfg_req_i;
  logic                      cfg_we_i;
  logic [AW-1:0]             cfg_addr_i;
  logic [BEW-1:0]            cfg_be_i;
  logic [ENTRY_WIDTH-1:0]    cfg_wdata_i;
  logic                      cfg_gnt_o;
  logic                      cfg_rvalid_o;
  logic [ENTRY_WIDTH-1:0]    cfg_rdata_o;
  logic [NUM_READERS-1:0]    rd_req_i;
  logic [NUM_READERS*AW-1:0] rd_addr_i;
  logic [NUM_READERS-1:0]    rd_gnt_o;
  logic [NUM_READERS-1:0]    rd_rvalid_o;
  logic [ENTRY_WIDTH-1:0]    rd_rdata_o;
  logic                      cfg_busy_o;
  logic                      err_o;
  logic                      ram_req_o;
  logic                      ram_we_o;
  logic [AW-1:0]             ram_addr_o;
  logic [BEW-1:0]            ram_be_o;
  logic [ENTRY_WIDTH-1:0]    ram_wdata_o;
  logic [ENTRY_WIDTH-1:0]    ram_rdata_i;

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_be_i, cfg_wdata_i,
    input  rd_req_i, rd_addr_i, ram_rdata_i,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o,
    output rd_gnt_o, rd_rvalid_o, rd_rdata_o,
    output cfg_busy_o, err_o,
    output ram_req_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o
  );

  modport master (
    output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_be_i, cfg_wdata_i,
    output rd_req_i, rd_addr_i, ram_rdata_i,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o,
    input  rd_gnt_o, rd_rvalid_o, rd_rdata_o,
    input  cfg_busy_o, err_o,
    input  ram_req_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o
  );

endinterface

// File: rtl/rv_iopmp_rr_arbiter.sv
// Round-robin one-hot picker: first set request at or after ptr_i, wrapping.
module rv_iopmp_rr_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = addr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] pos;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = ptr_i;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && req_i[pos]) begin
        valid_o    = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
      pos = (pos == IW'(N - 1)) ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/rv_iopmp_entry_arbiter.sv
// Shares the single-port entry SRAM between config and matching-logic readers.
// Optional perf counters are built when RV_IOPMP_ENTRY_ARB_PERF_EN is defined.
module rv_iopmp_entry_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int NUM_READERS    = 2,
  parameter int NUMBER_ENTRIES = 8,
  parameter int ENTRY_WIDTH    = rv_iopmp_pkg::ENTRY_WIDTH,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  rv_iopmp_entry_arbiter_if.slave bus
`ifdef RV_IOPMP_ENTRY_ARB_PERF_EN
  ,
  output logic [31:0] conflict_cnt_o,
  output logic [31:0] starve_evt_cnt_o
`endif
);

  localparam int AW = addr_width(NUMBER_ENTRIES);
  localparam int RW = addr_width(NUM_READERS);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [RW-1:0] rr_q, rr_d;
  logic [SW-1:0] starve_q, starve_d;
  arb_tag_t      tag_q, tag_d;
  logic          zero_q, zero_d;
  logic          busy_q, busy_d;

  logic [NUM_READERS-1:0] rd_req, pick_gnt;
  logic [RW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   cfg_win, rd_win, granted, oor, cfg_wr, starved, rvalid_any;
  logic [AW-1:0]          sel_addr;
  logic [ENTRY_WIDTH-1:0] ret_data;

  // Everything is held quiet while in reset, including combinational grants.
  assign rd_req = rst_ni ? bus.rd_req_i : '0;

  rv_iopmp_rr_arbiter #(.N(NUM_READERS), .IW(RW)) u_rr (
    .req_i   (rd_req),
    .ptr_i   (rr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    starved  = pick_valid & (starve_q == SW'(STARVE_LIMIT));
    cfg_win  = rst_ni & bus.cfg_req_i & ~starved;
    rd_win   = ~cfg_win & pick_valid;
    granted  = cfg_win | rd_win;
    sel_addr = cfg_win ? bus.cfg_addr_i : bus.rd_addr_i[pick_idx*AW +: AW];
    oor      = granted & ({1'b0, sel_addr} >= (AW+1)'(NUMBER_ENTRIES));
    cfg_wr   = cfg_win & bus.cfg_we_i;

    bus.cfg_gnt_o   = cfg_win;
    bus.rd_gnt_o    = rd_win ? pick_gnt : '0;
    bus.ram_req_o   = granted & ~oor;
    bus.ram_we_o    = bus.ram_req_o & cfg_wr;
    bus.ram_addr_o  = bus.ram_req_o ? sel_addr : '0;
    bus.ram_be_o    = bus.ram_req_o ? (cfg_win ? bus.cfg_be_i : '1) : '0;
    bus.ram_wdata_o = bus.ram_we_o ? bus.cfg_wdata_i : '0;
    bus.err_o       = oor;
    bus.cfg_busy_o  = cfg_wr | (busy_q & rst_ni);

    tag_d        = '0;
    tag_d.valid  = granted & ~cfg_wr;
    tag_d.is_cfg = cfg_win;
    tag_d.idx    = rd_win ? IDX_W'(pick_idx) : '0;
    zero_d       = oor;
    busy_d       = cfg_wr;

    rr_d = rr_q;
    if (rd_win) rr_d = (pick_idx == RW'(NUM_READERS - 1)) ? '0 : pick_idx + 1'b1;

    // Counts back-to-back cfg wins only while some reader is left waiting.
    starve_d = starve_q;
    if (rd_win || !pick_valid)                         starve_d = '0;
    else if (cfg_win && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;

    rvalid_any       = tag_q.valid & rst_ni;
    ret_data         = zero_q ? '0 : bus.ram_rdata_i;
    bus.cfg_rvalid_o = rvalid_any & tag_q.is_cfg;
    bus.cfg_rdata_o  = bus.cfg_rvalid_o ? ret_data : '0;
    bus.rd_rdata_o   = (rvalid_any & ~tag_q.is_cfg) ? ret_data : '0;
    for (int i = 0; i < NUM_READERS; i++) begin
      bus.rd_rvalid_o[i] = rvalid_any & ~tag_q.is_cfg & (tag_q.idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      starve_q <= '0;
      tag_q    <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
    end
  end

`ifdef RV_IOPMP_ENTRY_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] starve_evt_cnt_q, starve_evt_cnt_d;
  int unsigned n_act;

  always_comb begin
    n_act = (rst_ni & bus.cfg_req_i) ? 1 : 0;
    for (int i = 0; i < NUM_READERS; i++) begin
      if (rd_req[i]) n_act = n_act + 1;
    end
    conflict_cnt_d   = conflict_cnt_q + ((n_act >= 2) ? 32'd1 : 32'd0);
    starve_evt_cnt_d = starve_evt_cnt_q + ((rst_ni & bus.cfg_req_i & starved) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conflict_cnt_q   <= '0;
      starve_evt_cnt_q <= '0;
    end else begin
      conflict_cnt_q   <= conflict_cnt_d;
      starve_evt_cnt_q <= starve_evt_cnt_d;
    end
  end

  assign conflict_cnt_o   = conflict_cnt_q;
  assign starve_evt_cnt_o = starve_evt_cnt_q;
`endif

endmodule
